// File: rtl/btn_pkg.sv
// ----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the push-button front end. The debouncer and the
// classifier both import this package, so they share one clock-rate
// definition (100 MHz system clock).
//
// Contents:
//   ST_*                  3-bit FSM state encodings for the press classifier
//   LONG_CYC_DEFAULT      cycles a press must be held to count as "long" (1 s)
//   DOUBLE_CYC_DEFAULT    max gap after a release for a double click (300 ms)
//   REPEAT_CYC_DEFAULT    auto-repeat period while held after a long press
//                         (200 ms)
// ----------------------------------------------------------------------------
package btn_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRESS1 = 3'd1;
  localparam logic [2:0] ST_WAIT2  = 3'd2;
  localparam logic [2:0] ST_PRESS2 = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;

  localparam int unsigned LONG_CYC_DEFAULT   = 32'd100_000_000;
  localparam int unsigned DOUBLE_CYC_DEFAULT = 32'd30_000_000;
  localparam int unsigned REPEAT_CYC_DEFAULT = 32'd20_000_000;

endpackage

// File: rtl/button_press_classifier_if.sv
// ----------------------------------------------------------------------------
// button_press_classifier_if
// Bundles the debounced button level going into the classifier and the
// single-cycle event pulses coming out of it.
//
// Signals:
//   btn_in        debounced button level, high = pressed
//   click         one-cycle pulse, single click
//   double_click  one-cycle pulse, double click
//   long_press    one-cycle pulse, long-press threshold reached
//   repeat_pulse  one-cycle pulse per auto-repeat period (0 unless the
//                 BTN_REPEAT_EN build option is enabled)
//   busy          high while the classifier is not idle
//
// Modports:
//   master  the side that owns the button level and consumes the events
//   slave   the classifier itself
// ----------------------------------------------------------------------------
interface button_press_classifier_if;

  logic btn_in;
  logic click;
  logic double_click;
  logic long_press;
  logic repeat_pulse;
  logic busy;

  modport master (
    output btn_in,
    input  click,
    input  double_click,
    input  long_press,
    input  repeat_pulse,
    input  busy
  );

  modport slave (
    input  btn_in,
    output click,
    output double_click,
    output long_press,
    output repeat_pulse,
    output busy
  );

endinterface

// File: rtl/button_press_classifier.sv
// ----------------------------------------------------------------------------
// button_press_classifier
// Turns the debounced button level into single-cycle events for the menu /
// mode FSMs: single click, double click, long press and (optionally)
// auto-repeat while the button stays held after a long press.
//
// Parameters:
//   LONG_CYC    hold time in cycles that makes a press long          (>= 2)
//   DOUBLE_CYC  max gap in cycles between release and second press   (>= 2)
//   REPEAT_CYC  auto-repeat period in cycles (repeat build only)     (>= 2)
//
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   button_press_classifier_if.slave (btn_in in; click, double_click,
//         long_press, repeat_pulse, busy out; all outputs registered)
//
// Build option:
//   BTN_REPEAT_EN  when defined, HOLD counts while the button is held and
//                  fires repeat_pulse every REPEAT_CYC cycles; when undefined
//                  repeat_pulse is tied low and HOLD has no counter.
// ----------------------------------------------------------------------------
module button_press_classifier
  import btn_pkg::*;
#(
  parameter int unsigned LONG_CYC   = LONG_CYC_DEFAULT,
  parameter int unsigned DOUBLE_CYC = DOUBLE_CYC_DEFAULT,
  parameter int unsigned REPEAT_CYC = REPEAT_CYC_DEFAULT
) (
  input logic                       clk,
  input logic                       rst,
  button_press_classifier_if.slave  bus
);

  if (LONG_CYC < 2 || DOUBLE_CYC < 2 || REPEAT_CYC < 2) begin : g_param_check
    $error("button_press_classifier: cycle parameters must be at least 2");
  end

  localparam logic [31:0] LONG_LAST   = 32'(LONG_CYC - 1);
  localparam logic [31:0] DOUBLE_LAST = 32'(DOUBLE_CYC - 1);

  logic [2:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        btn_q;
  logic        click_q, click_d;
  logic        double_q, double_d;
  logic        long_q, long_d;
  logic        busy_q, busy_d;
  logic        repeat_d;
  logic        rise, fall;

  // btn_q resets high so a button already held when reset releases does not
  // look like a fresh press; it must be released and pressed again.
  assign rise = bus.btn_in & ~btn_q;
  assign fall = ~bus.btn_in & btn_q;

  // Next-state logic. The counter increments by default and is explicitly
  // cleared on every state transition.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 32'd1;
    click_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rise) begin
          state_d = ST_PRESS1;
        end
      end
      ST_PRESS1: begin
        if (fall) begin
          state_d = ST_WAIT2;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          long_d  = 1'b1;
        end
      end
      ST_WAIT2: begin
        // A second press wins over a timeout landing on the same edge.
        if (rise) begin
          state_d = ST_PRESS2;
          cnt_d   = '0;
        end else if (cnt_q == DOUBLE_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          click_d = 1'b1;
        end
      end
      ST_PRESS2: begin
        cnt_d = '0;
        if (fall) begin
          state_d  = ST_IDLE;
          double_d = 1'b1;
        end
      end
      ST_HOLD: begin
`ifdef BTN_REPEAT_EN
        // A release on the same edge as a repeat ends quietly.
        if (fall) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 32'(REPEAT_CYC - 1)) begin
          cnt_d    = '0;
          repeat_d = 1'b1;
        end
`else
        cnt_d = '0;
        if (fall) begin
          state_d = ST_IDLE;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, counter, button history and registered event outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      btn_q    <= 1'b1;
      click_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      btn_q    <= bus.btn_in;
      click_q  <= click_d;
      double_q <= double_d;
      long_q   <= long_d;
      busy_q   <= busy_d;
    end
  end

`ifdef BTN_REPEAT_EN
  logic repeat_q;

  // Registered auto-repeat pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      repeat_q <= 1'b0;
    end else begin
      repeat_q <= repeat_d;
    end
  end

  assign bus.repeat_pulse = repeat_q;
`else
  logic unused_repeat;
  assign unused_repeat    = repeat_d;
  assign bus.repeat_pulse = 1'b0;
`endif

  assign bus.click        = click_q;
  assign bus.double_click = double_q;
  assign bus.long_press   = long_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// ----------------------------------------------------------------------------
// tb_button_press_classifier
// Drives a pre-planned timeline of button levels and resets into the
// classifier. Expected pulses are derived from the press/release timeline
// with plain segment arithmetic and compared against the DUT every cycle,
// followed by a few hand-computed pins on notable edges.
// ----------------------------------------------------------------------------
module tb_button_press_classifier;

  localparam int LONG = 20;
  localparam int DBL  = 10;
  localparam int REP  = 5;
  localparam int MAXN = 512;

  logic clk = 1'b0;
  logic rst;

  button_press_classifier_if bus();

  button_press_classifier #(
    .LONG_CYC   (LONG),
    .DOUBLE_CYC (DBL),
    .REPEAT_CYC (REP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Timeline: value of btn_in and rst in effect at each rising edge.
  logic btnPlan [MAXN];
  logic rstPlan [MAXN];
  int   planLen = 0;
  logic modelReady = 1'b0;

  logic expClick [MAXN];
  logic expDouble[MAXN];
  logic expLong  [MAXN];
  logic expRepeat[MAXN];
  logic expBusy  [MAXN];

  logic gotClick [MAXN];
  logic gotDouble[MAXN];
  logic gotLong  [MAXN];
  logic gotRepeat[MAXN];
  logic gotBusy  [MAXN];

  int vectors     = 0;
  int miscompares = 0;

  int aRel, bRel2, cRise, eRise, eRel, gRel, hRel, hRst;

  // Appends len edges of the given levels; returns the first edge index.
  function automatic int addSeg(input logic lvl, input logic r, input int len);
    int start;
    start = planLen;
    for (int i = 0; i < len; i++) begin
      btnPlan[planLen] = lvl;
      rstPlan[planLen] = r;
      planLen++;
    end
    return start;
  endfunction

  // Level the classifier remembers from the previous edge (high after reset).
  function automatic logic prevLevel(input int e);
    if (e == 0) return 1'b1;
    return rstPlan[e-1] ? 1'b1 : btnPlan[e-1];
  endfunction

  function automatic int firstLevel(input int from, input logic lvl);
    for (int e = from; e < planLen; e++) begin
      if (btnPlan[e] == lvl) return e;
    end
    return planLen + 100;
  endfunction

  function automatic int nextReset(input int from);
    for (int e = from; e < planLen; e++) begin
      if (rstPlan[e]) return e;
    end
    return planLen + 100;
  endfunction

  // Walks the timeline press episode by press episode and records at which
  // edge each pulse must be decided; a reset cancels anything after it.
  task automatic buildModel();
    int n, r, rEnd, f1, r2, f2, endE;
    for (int e = 0; e < MAXN; e++) begin
      expClick[e] = 1'b0; expDouble[e] = 1'b0; expLong[e] = 1'b0;
      expRepeat[e] = 1'b0; expBusy[e] = 1'b0;
    end
    n = 0;
    while (n < planLen) begin
      r = -1;
      for (int e = n; e < planLen; e++) begin
        if (!rstPlan[e] && btnPlan[e] && !prevLevel(e)) begin
          r = e;
          break;
        end
      end
      if (r < 0) break;
      rEnd = nextReset(r + 1);
      f1   = firstLevel(r + 1, 1'b0);
      if (f1 > r + LONG) begin
        if (r + LONG < rEnd && r + LONG < planLen) expLong[r + LONG] = 1'b1;
`ifdef BTN_REPEAT_EN
        for (int k = 1; r + LONG + k * REP < f1; k++) begin
          if (r + LONG + k * REP < rEnd && r + LONG + k * REP < planLen)
            expRepeat[r + LONG + k * REP] = 1'b1;
        end
`endif
        endE = f1;
      end else begin
        r2 = firstLevel(f1 + 1, 1'b1);
        if (r2 - f1 <= DBL) begin
          f2 = firstLevel(r2 + 1, 1'b0);
          if (f2 < rEnd && f2 < planLen) expDouble[f2] = 1'b1;
          endE = f2;
        end else begin
          if (f1 + DBL < rEnd && f1 + DBL < planLen) expClick[f1 + DBL] = 1'b1;
          endE = f1 + DBL;
        end
      end
      if (rEnd < endE) endE = rEnd;
      for (int e = r; e < endE && e < planLen; e++) expBusy[e] = 1'b1;
      n = endE;
    end
  endtask

  task automatic checkOutput(input string name, input int edgeIdx,
                             input logic actual, input logic expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at edge %0d: got %0b, expected %0b",
               name, edgeIdx, actual, expected);
    end
  endtask

  task automatic checkCount(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drives the levels for edge n; on a fresh reset assertion the outputs
  // must clear right away, without waiting for a clock edge.
  task automatic applyStimulus(input int n);
    bus.btn_in = btnPlan[n];
    rst        = rstPlan[n];
    if (n > 0 && rstPlan[n] && !rstPlan[n-1]) begin
      #1;
      checkOutput("rst_async_click",  n, bus.click,        1'b0);
      checkOutput("rst_async_double", n, bus.double_click, 1'b0);
      checkOutput("rst_async_long",   n, bus.long_press,   1'b0);
      checkOutput("rst_async_repeat", n, bus.repeat_pulse, 1'b0);
      checkOutput("rst_async_busy",   n, bus.busy,         1'b0);
    end
  endtask

  // Plan construction and stimulus driving.
  initial begin
    void'(addSeg(1'b0, 1'b1, 3));
    // single click
    void'(addSeg(1'b0, 1'b0, 5));
    void'(addSeg(1'b1, 1'b0, 5));
    aRel = addSeg(1'b0, 1'b0, 20);
    // double click
    void'(addSeg(1'b1, 1'b0, 5));
    void'(addSeg(1'b0, 1'b0, 4));
    void'(addSeg(1'b1, 1'b0, 3));
    bRel2 = addSeg(1'b0, 1'b0, 15);
    // long holds: 31 (repeats at +25,+30), 30 (release beats +30), 37
    cRise = addSeg(1'b1, 1'b0, 31);
    void'(addSeg(1'b0, 1'b0, 15));
    void'(addSeg(1'b1, 1'b0, 30));
    void'(addSeg(1'b0, 1'b0, 15));
    eRise = addSeg(1'b1, 1'b0, 37);
    eRel  = addSeg(1'b0, 1'b0, 15);
    // press of exactly LONG, then a second press: double, no long
    void'(addSeg(1'b1, 1'b0, 20));
    void'(addSeg(1'b0, 1'b0, 5));
    void'(addSeg(1'b1, 1'b0, 2));
    void'(addSeg(1'b0, 1'b0, 15));
    // gap of exactly DBL still makes a double
    void'(addSeg(1'b1, 1'b0, 3));
    void'(addSeg(1'b0, 1'b0, 10));
    void'(addSeg(1'b1, 1'b0, 2));
    void'(addSeg(1'b0, 1'b0, 15));
    // gap of DBL+1 gives two single clicks
    void'(addSeg(1'b1, 1'b0, 3));
    void'(addSeg(1'b0, 1'b0, 11));
    void'(addSeg(1'b1, 1'b0, 2));
    void'(addSeg(1'b0, 1'b0, 15));
    // button held through reset release is ignored until re-pressed
    void'(addSeg(1'b1, 1'b1, 3));
    void'(addSeg(1'b1, 1'b0, 50));
    void'(addSeg(1'b0, 1'b0, 5));
    void'(addSeg(1'b1, 1'b0, 3));
    gRel = addSeg(1'b0, 1'b0, 15);
    // reset four cycles into the double-click wait
    void'(addSeg(1'b1, 1'b0, 3));
    hRel = addSeg(1'b0, 1'b0, 4);
    hRst = addSeg(1'b0, 1'b1, 3);
    void'(addSeg(1'b0, 1'b0, 20));

    buildModel();
    modelReady = 1'b1;

    bus.btn_in = btnPlan[0];
    rst        = rstPlan[0];
    for (int n = 1; n < planLen; n++) begin
      @(negedge clk);
      applyStimulus(n);
    end
  end

  // Per-cycle compare against the model, then hand-computed pins.
  initial begin
    int nClick, nDouble, nLong, nRepeat;
    wait (modelReady);
    nClick = 0; nDouble = 0; nLong = 0; nRepeat = 0;
    for (int e = 0; e < planLen; e++) begin
      @(posedge clk);
      #1;
      gotClick[e]  = bus.click;
      gotDouble[e] = bus.double_click;
      gotLong[e]   = bus.long_press;
      gotRepeat[e] = bus.repeat_pulse;
      gotBusy[e]   = bus.busy;
      checkOutput("click",        e, bus.click,        expClick[e]);
      checkOutput("double_click", e, bus.double_click, expDouble[e]);
      checkOutput("long_press",   e, bus.long_press,   expLong[e]);
      checkOutput("repeat_pulse", e, bus.repeat_pulse, expRepeat[e]);
      checkOutput("busy",         e, bus.busy,         expBusy[e]);
      nClick  += int'(bus.click);
      nDouble += int'(bus.double_click);
      nLong   += int'(bus.long_press);
      nRepeat += int'(bus.repeat_pulse);
    end

    checkOutput("pin_model_click_a",   aRel + 10,  expClick[aRel + 10],   1'b1);
    checkOutput("pin_model_double_b",  bRel2,      expDouble[bRel2],      1'b1);
    checkOutput("pin_model_long_c",    cRise + 20, expLong[cRise + 20],   1'b1);
    checkOutput("pin_model_click_h",   hRel + 10,  expClick[hRel + 10],   1'b0);
    checkOutput("pin_reset_busy",      0,          gotBusy[0],            1'b0);
    checkOutput("pin_click_a",         aRel + 10,  gotClick[aRel + 10],   1'b1);
    checkOutput("pin_click_a_early",   aRel + 9,   gotClick[aRel + 9],    1'b0);
    checkOutput("pin_double_b",        bRel2,      gotDouble[bRel2],      1'b1);
    checkOutput("pin_long_c",          cRise + 20, gotLong[cRise + 20],   1'b1);
    checkOutput("pin_busy_e_held",     eRel - 1,   gotBusy[eRel - 1],     1'b1);
    checkOutput("pin_busy_e_release",  eRel,       gotBusy[eRel],         1'b0);
    checkOutput("pin_click_g",         gRel + 10,  gotClick[gRel + 10],   1'b1);
    checkOutput("pin_busy_h_reset",    hRst,       gotBusy[hRst],         1'b0);
    checkCount("count_click",  nClick,  4);
    checkCount("count_double", nDouble, 3);
    checkCount("count_long",   nLong,   3);
`ifdef BTN_REPEAT_EN
    checkOutput("pin_model_repeat_e", eRise + 25, expRepeat[eRise + 25], 1'b1);
    checkOutput("pin_repeat_c_30",    cRise + 30, gotRepeat[cRise + 30], 1'b1);
    checkOutput("pin_repeat_e_25",    eRise + 25, gotRepeat[eRise + 25], 1'b1);
    checkOutput("pin_repeat_e_35",    eRise + 35, gotRepeat[eRise + 35], 1'b1);
    checkCount("count_repeat", nRepeat, 6);
`else
    checkCount("count_repeat", nRepeat, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
